// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Sits on the CPU data-memory port inside a 16-byte window: TXDATA pushes
// bytes into a circular FIFO, STATUS reports FIFO/FSM state, DIV sets the
// runtime baud divisor. A serializer drains the FIFO LSB first on tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR       = 32'h8000_1000,
    parameter int unsigned CLK_DIV         = 16,
    parameter int unsigned FIFO_DEPTH_POW2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [3:0]  byte_en,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_POW2;
    localparam int unsigned PW    = FIFO_DEPTH_POW2;
    localparam int unsigned CW    = FIFO_DEPTH_POW2 + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   bit_div;    // divisor latched for the bit currently on the line
    logic [15:0]   div_reg;
    logic          overflow;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          hit;
    logic [1:0]    offset;
    logic          wr;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          tick;
    logic          ovf_set;
    logic          ovf_clr;
    logic [15:0]   div_eff;
    logic [7:0]    head;

    // Address bits below word granularity and unused write lanes are ignored.
    logic          unused_bits;
    assign unused_bits = ^{A[1:0], WD[31:16], byte_en[3:2]};

    assign hit      = (A[31:4] == BASE_ADDR[31:4]);
    assign offset   = A[3:2];
    assign wr       = hit && WE;
    assign push_req = wr && (offset == OFF_TXDATA) && byte_en[0];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign tick     = (baud_cnt == bit_div - 16'd1);
    // The FSM takes the head either from IDLE or at the final stop-bit tick.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && tick));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && !push_ok;
    assign ovf_clr  = wr && (offset == OFF_STATUS) && byte_en[0] && WD[3];
    assign div_eff  = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || !empty;

    // FIFO storage write port.
    // NOTE: the data array has no reset; pointers and count alone define
    // validity, so clearing them on reset discards the contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= WD[7:0];
        end
    end

    // FIFO pointers and occupancy count.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Divisor register and sticky overflow flag; a set beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg  <= 16'(CLK_DIV);
            overflow <= 1'b0;
        end else begin
            if (wr && (offset == OFF_DIV) && byte_en[0]) begin
                div_reg[7:0] <= WD[7:0];
            end
            if (wr && (offset == OFF_DIV) && byte_en[1]) begin
                div_reg[15:8] <= WD[15:8];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM with registered tx; the divisor is re-latched at every
    // bit boundary so a mid-bit DIV write only affects the following bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            bit_div  <= 16'd1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        bit_div  <= div_eff;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_div  <= div_eff;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_div  <= div_eff;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_div  <= div_eff;
                        if (pop) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux: combinational, no side effects; misses and unmapped offsets read 0.
    // NOTE: RD gets a default before the case so no path can infer a latch.
    always_comb begin
        RD = '0;
        if (hit) begin
            unique case (offset)
                OFF_STATUS: RD = {16'b0, 8'(count), 4'b0, overflow,
                                  (state != IDLE), empty, full};
                OFF_DIV:    RD = {16'b0, div_reg};
                default:    RD = '0;
            endcase
        end
    end

endmodule
